scr1_tcm_loader: RTL

//  Boot-time initiator for port B of the TCM dual-port memory. Receives a byte stream
//  (e.g. from a UART RX), assembles little-endian 32-bit words and issues byte-enabled

---
 rtl/scr1_tcm_loader.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/scr1_tcm_loader.sv
// scr1_tcm_loader
//   Boot-time initiator for TCM port B. Receives a length-prefixed byte stream,
//   packs little-endian 32-bit words and writes them with byte enables. The core
//   is held in reset until the whole image has been written.
//
//   Frame: 4 length bytes N (LE), then N payload bytes, then one checksum byte
//   when SCR1_TCM_LOADER_CKSUM_EN is defined.
//
//   Build option:
//     SCR1_TCM_LOADER_CKSUM_EN  - checks a trailing mod-256 sum byte after the
//                                 payload. Without it the checksum state and the
//                                 sum register are not built.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   LEN   | collecting the four little-endian length bytes
//   DATA  | collecting payload bytes, one word write per full/last word
//   CKSUM | waiting for the checksum byte (SCR1_TCM_LOADER_CKSUM_EN only)
//   DONE  | image loaded, core released; held until rst
//   ERR   | bad length or checksum; core kept in reset until rst

module scr1_tcm_loader #(
    parameter int unsigned SCR1_WIDTH  = 32,
    parameter int unsigned SCR1_SIZE   = 32'h0001_0000,
    parameter int unsigned SCR1_NBYTES = SCR1_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            wenb,
    output logic [SCR1_NBYTES-1:0]          webb,
    output logic [$clog2(SCR1_SIZE)-3:0]    addrb,
    output logic [SCR1_WIDTH-1:0]           datab,
    output logic                            renb,
    output logic                            core_rst_n,
    output logic                            load_done,
    output logic                            load_err
);

    localparam int unsigned AW = $clog2(SCR1_SIZE);
    localparam int unsigned LW = $clog2(SCR1_NBYTES);

    localparam logic [AW:0]    REM_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]  IDX_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]  LANE_LAST = {LW{1'b1}};
    localparam logic [1:0]     LEN_LAST  = 2'd3;
    localparam logic [1:0]     LEN_ONE   = 2'd1;

`ifdef SCR1_TCM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_CKSUM = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;
`endif

    state_t                     state;
    state_t                     state_nxt;

    logic                       rdy_q;
    logic                       accepting;
    logic                       accept;

    logic [1:0]                 len_cnt;
    logic [23:0]                len_lo;
    logic [31:0]                len_full;
    logic                       len_over;
    logic                       len_zero;

    // rem counts payload bytes still expected; idx is the byte offset in the image
    logic [AW:0]                rem;
    logic [AW-1:0]              idx;
    logic [LW-1:0]              lane;
    logic                       last_byte;
    logic                       word_full;
    logic                       issue;

    logic [SCR1_NBYTES-1:0]     mask;
    logic [SCR1_NBYTES-1:0]     lane_bit;
    logic [SCR1_WIDTH-1:0]      acc;
    logic [SCR1_WIDTH-1:0]      acc_merged;

    logic                       payload_end_to_cksum;
    logic                       cksum_ok;

    assign renb = 1'b0;

    // Handshake: ready only in byte-consuming states, and not in the cycle after reset
    assign accepting = (state == ST_LEN) || (state == ST_DATA)
`ifdef SCR1_TCM_LOADER_CKSUM_EN
                       || (state == ST_CKSUM)
`endif
                       ;
    assign in_ready  = rdy_q && accepting;
    assign accept    = in_valid && in_ready;

    assign len_full  = {in_data, len_lo};
    assign len_over  = len_full > SCR1_SIZE;
    assign len_zero  = (len_full == 32'd0);

    assign lane      = idx[LW-1:0];
    assign last_byte = (rem == REM_ONE);
    assign word_full = (lane == LANE_LAST);
    assign issue     = word_full || last_byte;

`ifdef SCR1_TCM_LOADER_CKSUM_EN
    assign payload_end_to_cksum = 1'b1;
`else
    assign payload_end_to_cksum = 1'b0;
`endif

    // Merge the incoming byte into the word being assembled
    always_comb begin
        lane_bit       = '0;
        lane_bit[lane] = 1'b1;
        acc_merged     = acc;
        acc_merged[{lane, 3'b000} +: 8] = in_data;
    end

`ifdef SCR1_TCM_LOADER_CKSUM_EN
    logic [7:0] sum;

    // Running mod-256 sum of the payload bytes
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum <= 8'd0;
        end else if (accept && (state == ST_DATA)) begin
            sum <= sum + in_data;
        end
    end

    assign cksum_ok = (in_data == sum);
`else
    assign cksum_ok = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt  = state;
        core_rst_n = 1'b0;
        load_done  = 1'b0;
        load_err   = 1'b0;
        case (state)
            ST_LEN: begin
                if (accept && (len_cnt == LEN_LAST)) begin
                    if (len_over) begin
                        state_nxt = ST_ERR;
                    end else if (len_zero) begin
`ifdef SCR1_TCM_LOADER_CKSUM_EN
                        state_nxt = payload_end_to_cksum ? ST_CKSUM : ST_DONE;
`else
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // The final word write is registered on this same edge, so the
                // next state is entered together with the last wenb pulse.
                if (accept && last_byte) begin
`ifdef SCR1_TCM_LOADER_CKSUM_EN
                    state_nxt = payload_end_to_cksum ? ST_CKSUM : ST_DONE;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef SCR1_TCM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (accept) begin
                    state_nxt = cksum_ok ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: begin
                core_rst_n = 1'b1;
                load_done  = 1'b1;
            end
            ST_ERR: begin
                load_err = 1'b1;
            end
            default: begin
                state_nxt = ST_LEN;
            end
        endcase
    end

    // Length capture, word assembly and the registered port-B write
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_q   <= 1'b0;
            len_cnt <= 2'd0;
            len_lo  <= 24'd0;
            rem     <= '0;
            idx     <= '0;
            mask    <= '0;
            acc     <= '0;
            wenb    <= 1'b0;
            webb    <= '0;
            addrb   <= '0;
            datab   <= '0;
        end else begin
            rdy_q <= 1'b1;
            wenb  <= 1'b0;
            webb  <= '0;
            if (accept) begin
                case (state)
                    ST_LEN: begin
                        len_cnt <= len_cnt + LEN_ONE;
                        len_lo  <= {in_data, len_lo[23:8]};
                        if (len_cnt == LEN_LAST) begin
                            rem <= len_full[AW:0];
                            idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        idx <= idx + IDX_ONE;
                        rem <= rem - REM_ONE;
                        if (issue) begin
                            wenb  <= 1'b1;
                            webb  <= mask | lane_bit;
                            addrb <= idx[AW-1:LW];
                            datab <= acc_merged;
                            // Clear so a short last word carries no bytes from the previous one
                            mask  <= '0;
                            acc   <= '0;
                        end else begin
                            mask  <= mask | lane_bit;
                            acc   <= acc_merged;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
